// File: rtl/axi_error_slave_if.sv
// rtl/axi_error_slave_if.sv - AXI4 bus bundle with slave-side (in) and master-side (out) views
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 12,
    parameter int unsigned AXI_USER_WIDTH = 0
);
    // A zero-width user field still needs one physical bit to be declarable.
    localparam int unsigned USER_W = (AXI_USER_WIDTH > 0) ? AXI_USER_WIDTH : 1;
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [USER_W-1:0]         aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]         w_strb;
    logic                      w_last;
    logic [USER_W-1:0]         w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [USER_W-1:0]         b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [USER_W-1:0]         ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [USER_W-1:0]         r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport in (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

    modport out (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );
endinterface

// File: rtl/axi_error_slave.sv
// rtl/axi_error_slave.sv - AXI slave that answers every burst with an error response
module axi_error_slave #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 12,
    parameter int unsigned AXI_USER_WIDTH = 0,
    parameter logic [1:0]  RESP           = 2'b11,
    parameter logic [63:0] RDATA          = 64'hBADC_AB1E_DEAD_BEEF
) (
    input logic clk_i,
    input logic rst_i,
    AXI_BUS.in  slv
);
    localparam int unsigned USER_W = (AXI_USER_WIDTH > 0) ? AXI_USER_WIDTH : 1;
    // Size cast truncates for narrow buses and zero-extends for wide ones.
    localparam logic [AXI_DATA_WIDTH-1:0] RDATA_BUS = AXI_DATA_WIDTH'(RDATA);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;

    logic [AXI_ID_WIDTH-1:0] w_id_q;
    logic [USER_W-1:0]       w_user_q;
    logic [AXI_ID_WIDTH-1:0] r_id_q;
    logic [USER_W-1:0]       r_user_q;
    logic [7:0]              r_len_q;
    logic [7:0]              r_cnt_q;

    logic aw_ready, w_ready, b_valid;
    logic ar_ready, r_valid, r_last;

    // Write state register plus the AW fields echoed back on B.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_user_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            if (w_state_q == W_IDLE && slv.aw_valid) begin
                w_id_q   <= slv.aw_id;
                w_user_q <= slv.aw_user;
            end
        end
    end

    // Write next-state and handshake decode: accept AW, sink W until last, then one B.
    always_comb begin
        w_state_d = w_state_q;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                aw_ready = 1'b1;
                if (slv.aw_valid) w_state_d = W_DATA;
            end
            W_DATA: begin
                w_ready = 1'b1;
                if (slv.w_valid && slv.w_last) w_state_d = W_RESP;
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (slv.b_ready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read state register, AR fields and the full-width beat counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_user_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            if (r_state_q == R_IDLE && slv.ar_valid) begin
                r_id_q   <= slv.ar_id;
                r_user_q <= slv.ar_user;
                r_len_q  <= slv.ar_len;
                r_cnt_q  <= '0;
            end else if (r_state_q == R_DATA && slv.r_ready && !r_last) begin
                r_cnt_q <= r_cnt_q + 8'd1;
            end
        end
    end

    // Read next-state and handshake decode: len+1 beats, last flagged on the final one.
    always_comb begin
        r_state_d = r_state_q;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        r_last    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                ar_ready = 1'b1;
                if (slv.ar_valid) r_state_d = R_DATA;
            end
            R_DATA: begin
                r_valid = 1'b1;
                r_last  = (r_cnt_q == r_len_q);
                if (slv.r_ready && r_last) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign slv.aw_ready = aw_ready;
    assign slv.w_ready  = w_ready;
    assign slv.b_valid  = b_valid;
    assign slv.b_id     = w_id_q;
    assign slv.b_resp   = RESP;
    assign slv.b_user   = w_user_q;

    assign slv.ar_ready = ar_ready;
    assign slv.r_valid  = r_valid;
    assign slv.r_last   = r_last;
    assign slv.r_id     = r_id_q;
    assign slv.r_resp   = RESP;
    assign slv.r_data   = RDATA_BUS;
    assign slv.r_user   = r_user_q;
endmodule

// File: tb/tb_axi_error_slave.sv
// tb/tb_axi_error_slave.sv - directed self-checking bench for axi_error_slave
module tb_axi_error_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [31:0] EXP_RDATA = 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    AXI_BUS #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .AXI_ID_WIDTH  (12),
        .AXI_USER_WIDTH(0)
    ) bus ();

    axi_error_slave #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .AXI_ID_WIDTH  (12),
        .AXI_USER_WIDTH(0)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .slv  (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the AR handshake edge.
    task automatic issue_ar(input logic [11:0] id, input logic [7:0] len);
        bus.ar_id    = id;
        bus.ar_len   = len;
        bus.ar_addr  = 32'h1234_5670;
        bus.ar_valid = 1'b1;
        @(negedge clk);
        check("ar_ready_idle", bus.ar_ready, 1);
        @(posedge clk);
        #1 bus.ar_valid = 1'b0;
    endtask

    // mode 0: r_ready always 1; mode 1: r_ready pattern 1,0,0,1,0,0,...
    task automatic read_data(input logic [11:0] id, input logic [7:0] len, input int mode);
        int beats = 0, cyc = 0, lasts = 0;
        int e_valid = 0, e_id = 0, e_last = 0, e_data = 0, e_resp = 0, extra = 0;
        bit first = 1'b1;
        while (beats <= int'(len) && cyc < 4000) begin
            bus.r_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            @(negedge clk);
            if (first) check("r_valid_first", bus.r_valid, 1);
            first = 1'b0;
            if (!bus.r_valid) e_valid++;
            else begin
                if (bus.r_id !== id) e_id++;
                if (bus.r_resp !== 2'b11) e_resp++;
                if (bus.r_data !== EXP_RDATA) e_data++;
                if (bus.r_last !== (beats == int'(len))) e_last++;
                if (bus.r_ready) begin
                    if (bus.r_last) lasts++;
                    beats++;
                end
            end
            @(posedge clk);
            #1 cyc++;
        end
        bus.r_ready = 1'b1;
        check("rd_beats", beats, int'(len) + 1);
        check("rd_last_count", lasts, 1);
        check("rd_valid_gaps", e_valid, 0);
        check("rd_id_bad", e_id, 0);
        check("rd_resp_bad", e_resp, 0);
        check("rd_data_bad", e_data, 0);
        check("rd_last_bad", e_last, 0);
        @(negedge clk);
        check("ar_ready_after", bus.ar_ready, 1);
        check("r_valid_after", bus.r_valid, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.r_valid) extra++;
        end
        check("rd_extra_beats", extra, 0);
        @(posedge clk);
        #1 bus.r_ready = 1'b0;
    endtask

    // Called at posedge+1; AW, nbeats of W, then B with stall cycles of b_ready=0.
    task automatic write_burst(input logic [11:0] id, input int nbeats, input int stall);
        int e_w = 0;
        bus.aw_id    = id;
        bus.aw_len   = 8'(nbeats - 1);
        bus.aw_valid = 1'b1;
        @(negedge clk);
        check("aw_ready_idle", bus.aw_ready, 1);
        @(posedge clk);
        #1 bus.aw_valid = 1'b0;
        bus.w_valid = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            bus.w_last = (i == nbeats - 1);
            bus.w_data = 32'(i);
            @(negedge clk);
            if (bus.w_ready !== 1'b1) e_w++;
            check("b_valid_during_w", bus.b_valid, 0);
            @(posedge clk);
            #1;
        end
        check("w_ready_bad", e_w, 0);
        bus.w_valid = 1'b0;
        bus.w_last  = 1'b0;
        bus.b_ready = (stall == 0);
        @(negedge clk);
        check("b_valid_first", bus.b_valid, 1);
        check("b_id", bus.b_id, 64'(id));
        check("b_resp", bus.b_resp, 2'b11);
        check("w_ready_in_resp", bus.w_ready, 0);
        if (stall > 0) begin
            for (int k = 1; k < stall; k++) begin
                @(posedge clk);
                @(negedge clk);
                check("b_valid_held", bus.b_valid, 1);
                check("b_id_held", bus.b_id, 64'(id));
            end
            @(posedge clk);
            #1 bus.b_ready = 1'b1;
            @(negedge clk);
            check("b_valid_at_ready", bus.b_valid, 1);
        end
        @(posedge clk);
        #1 bus.b_ready = 1'b0;
        @(negedge clk);
        check("aw_ready_after", bus.aw_ready, 1);
        check("b_valid_after", bus.b_valid, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra;
        bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = 3'd2;
        bus.aw_burst = 2'b01; bus.aw_lock = 1'b0; bus.aw_cache = '0; bus.aw_prot = '0;
        bus.aw_qos = '0; bus.aw_region = '0; bus.aw_user = '0; bus.aw_valid = 1'b0;
        bus.w_data = '0; bus.w_strb = '1; bus.w_last = 1'b0; bus.w_user = '0;
        bus.w_valid = 1'b0; bus.b_ready = 1'b0;
        bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = 3'd2;
        bus.ar_burst = 2'b01; bus.ar_lock = 1'b0; bus.ar_cache = '0; bus.ar_prot = '0;
        bus.ar_qos = '0; bus.ar_region = '0; bus.ar_user = '0; bus.ar_valid = 1'b0;
        bus.r_ready = 1'b0;

        // Reset state, sampled while reset is still asserted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_aw_ready", bus.aw_ready, 1);
        check("rst_ar_ready", bus.ar_ready, 1);
        check("rst_w_ready", bus.w_ready, 0);
        check("rst_b_valid", bus.b_valid, 0);
        check("rst_r_valid", bus.r_valid, 0);
        check("rst_r_last", bus.r_last, 0);
        check("rst_b_id", bus.b_id, 0);
        check("rst_r_id", bus.r_id, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_aw_ready", bus.aw_ready, 1);
        check("post_rst_ar_ready", bus.ar_ready, 1);
        @(posedge clk);
        #1;

        // Four-beat read, always ready.
        issue_ar(12'd5, 8'd3);
        read_data(12'd5, 8'd3, 0);

        // W presented before AW must stall.
        bus.w_valid = 1'b1;
        bus.w_last  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("w_ready_before_aw", bus.w_ready, 0);
            @(posedge clk);
            #1;
        end
        write_burst(12'd2, 1, 3);

        // Eight beats under r_ready backpressure.
        issue_ar(12'd9, 8'd7);
        read_data(12'd9, 8'd7, 1);

        // Maximum burst length.
        issue_ar(12'd1, 8'd255);
        read_data(12'd1, 8'd255, 0);

        // AR and AW accepted in the same cycle.
        fork
            begin
                issue_ar(12'd6, 8'd3);
                read_data(12'd6, 8'd3, 0);
            end
            begin
                write_burst(12'd4, 4, 0);
            end
        join

        // Reset during beat 2 of a four-beat read.
        issue_ar(12'd3, 8'd3);
        bus.r_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_beat1", bus.r_valid, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_beat2", bus.r_valid, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_r_valid", bus.r_valid, 0);
        check("mid_rst_ar_ready", bus.ar_ready, 1);
        check("mid_rst_r_last", bus.r_last, 0);
        check("mid_rst_r_id", bus.r_id, 0);
        check("mid_rst_b_id", bus.b_id, 0);
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.r_valid) extra++;
        end
        check("mid_rst_no_beats", extra, 0);
        bus.r_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_error_slave.md
AXI_ERROR_SLAVE -- requirements
Module: axi_error_slave

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, address width of the slv port.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, data width of the slv port.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 12, ID width of the slv port; sized to match a crossbar master-side ID (slave ID + log2 of slave count).
REQ-004 SHALL have parameter AXI_USER_WIDTH, default 0, user width of the slv port.
REQ-005 SHALL have parameter RESP, default 2'b11, response code returned on every B and R beat (DECERR).
REQ-006 SHALL have parameter RDATA, default 64'hBADC_AB1E_DEAD_BEEF, pattern driven on r_data, truncated or zero-extended to AXI_DATA_WIDTH.
REQ-007 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-009 SHALL have port slv, AXI_BUS.in, per parameters, the AXI port fed by one crossbar master port (directly or through a register cut).

Function
REQ-010 SHALL implement independent write and read FSMs; neither SHALL wait on the other.
REQ-011 SHALL implement write FSM states W_IDLE, W_DATA and W_RESP.
- W_IDLE: aw_ready=1.
- On AW handshake: latch aw_id and aw_user, then go to W_DATA.
REQ-012 SHALL in W_DATA drive w_ready=1, discard w_data/w_strb, and move to W_RESP on a W handshake with w_last=1; beats with w_last=0 keep the state.
REQ-013 SHALL in W_RESP drive b_valid=1, b_id=latched ID, b_resp=RESP, b_user=latched user, holding all stable until b_ready; on B handshake go to W_IDLE.
REQ-014 SHALL drive w_ready=0 outside W_DATA; W data arriving before its AW is stalled, not dropped.
REQ-015 SHALL implement read FSM states R_IDLE and R_DATA.
- R_IDLE: ar_ready=1.
- On AR handshake: latch ar_id, ar_len and ar_user, clear the 8-bit beat counter, go to R_DATA.
REQ-016 SHALL in R_DATA drive r_valid=1, r_id=latched ID, r_resp=RESP, r_data=RDATA, r_user=latched user, and r_last=1 only when counter equals latched len.
REQ-017 SHALL increment the beat counter on each R handshake with r_last=0, and go to R_IDLE on the R handshake with r_last=1.
REQ-018 SHALL hold all R outputs and the counter unchanged while r_valid=1 and r_ready=0.
REQ-019 SHALL compare the counter at full 8-bit width; len=255 yields exactly 256 beats with no early wrap.
REQ-020 SHALL ignore ar_addr, ar_burst, ar_size, aw_addr, aw_burst, aw_size, lock, cache, prot, qos and region fields.
REQ-021 SHALL meet these latencies:
- AR handshake at cycle t -> first r_valid at t+1.
- AW handshake at t -> w_ready at t+1.
- Last W handshake at t -> b_valid at t+1.
- B or final R handshake at t -> aw_ready or ar_ready at t+1.
REQ-022 SHALL register every ready and valid output (state-decoded); no combinational path from any slv input to any slv output.
REQ-023 SHALL accept simultaneous AR and AW handshakes in the same cycle, serving both with no added latency.
REQ-024 SHALL have at most one write and one read transaction outstanding.

Reset
REQ-025 SHALL, while rst_i=1 at a clock edge, enter W_IDLE and R_IDLE and clear the counter and latched ID, len and user.
REQ-026 SHALL drive outputs during and after reset as follows: aw_ready=1, ar_ready=1, w_ready=0, b_valid=0, r_valid=0, r_last=0, b_id=0, r_id=0.
REQ-027 SHALL abandon any burst in progress when reset is applied mid-burst, with no B or R beats emitted after reset for it.

Verification
REQ-028 SHALL cover: AR id=5 len=3, r_ready=1 -> 4 R beats on consecutive cycles starting t+1, r_id=5, r_resp=2'b11, r_last only on beat 4, ar_ready=1 the cycle after.
REQ-029 SHALL cover: AW id=2, then one W beat w_last=1 -> b_valid next cycle, b_id=2, b_resp=2'b11; with b_ready=0 for 3 cycles, b_valid and b_id are held.
REQ-030 SHALL cover: AR len=7 with r_ready toggling 1,0,0,1,... -> exactly 8 beats, r_data=RDATA on every beat, outputs stable during stalls.
REQ-031 SHALL cover: AR len=255 -> exactly 256 beats, r_last asserted once on beat 256.
REQ-032 SHALL cover: AR and AW handshakes in the same cycle (AW len=3, 4 W beats) -> R burst and B complete with the same latency as the isolated cases.
REQ-033 SHALL cover: rst_i=1 for one cycle during beat 2 of a len=3 read -> r_valid=0 and ar_ready=1 the next cycle, with no further R beats.
